// File: rtl/score_keeper_pkg.sv
// Shared constants for the score keeper.
//   BLANK      : digit code that turns a seven-segment digit off
//   IDLE/FLASH : state encoding for the winner-flash FSM
package score_keeper_pkg;

    localparam logic [3:0] BLANK = 4'b1011;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLASH = 1'b1;

    // Winner register values
    localparam logic WIN_P1 = 1'b0;
    localparam logic WIN_P2 = 1'b1;

endpackage

// File: rtl/score_keeper_bcd_counter.sv
// Two-digit BCD counter, 0..99, saturating at 99.
//   clk  : clock
//   rst  : synchronous active-high reset (to 00)
//   clr  : synchronous clear (to 00)
//   inc  : add one when high at the clock edge
//   tens : tens digit, BCD
//   ones : ones digit, BCD
module bcd_counter_99 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic at_max;

    assign at_max = (tens == 4'd9) && (ones == 4'd9);

    // BCD increment with carry from ones into tens; holds at 99
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc && !at_max) begin
            if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper with a blinking winner flash.
//   clk          : clock
//   rst          : synchronous active-high reset
//   p1_win       : one-cycle pulse, player 1 won a game
//   p2_win       : one-cycle pulse, player 2 won a game
//   clear_scores : level, zeroes both scores and stops any flash
//   num1..num4   : digit codes P1 tens, P1 ones, P2 tens, P2 ones
//   flashing     : high while the winner flash is running
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned FLASH_CYCLES = 100_000_000,
    parameter int unsigned BLINK_HALF   = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       clear_scores,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       flashing
);

    localparam int unsigned FW = $clog2(FLASH_CYCLES);
    localparam int unsigned BW = $clog2(2 * BLINK_HALF);

    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);

    logic [0:0]    state, state_nx;
    logic          winner, winner_nx;
    logic [FW-1:0] flash_cnt, flash_nx;
    logic [BW-1:0] blink_cnt, blink_nx;

    logic       accept;
    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
    logic       blank_phase, blank_p1, blank_p2;

    // A draw is not a win; clear overrides any win in the same cycle
    assign accept = (p1_win ^ p2_win) & ~clear_scores;

    bcd_counter_99 u_p1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear_scores),
        .inc  (accept & p1_win),
        .tens (p1_tens),
        .ones (p1_ones)
    );

    bcd_counter_99 u_p2 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear_scores),
        .inc  (accept & p2_win),
        .tens (p2_tens),
        .ones (p2_ones)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= WIN_P1;
            flash_cnt <= '0;
            blink_cnt <= '0;
        end else begin
            state     <= state_nx;
            winner    <= winner_nx;
            flash_cnt <= flash_nx;
            blink_cnt <= blink_nx;
        end
    end

    // Next state: a win (re)starts the flash window from zero
    always_comb begin
        state_nx  = state;
        winner_nx = winner;
        flash_nx  = flash_cnt;
        blink_nx  = blink_cnt;
        if (clear_scores) begin
            state_nx = IDLE;
            flash_nx = '0;
            blink_nx = '0;
        end else if (accept) begin
            state_nx  = FLASH;
            winner_nx = p2_win ? WIN_P2 : WIN_P1;
            flash_nx  = '0;
            blink_nx  = '0;
        end else if (state == FLASH) begin
            if (flash_cnt == FLASH_LAST) begin
                state_nx = IDLE;
                flash_nx = '0;
                blink_nx = '0;
            end else begin
                flash_nx = flash_cnt + FW'(1);
                blink_nx = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
            end
        end
    end

    // Second half of each blink period hides the winner's digits
    assign blank_phase = (state == FLASH) && (blink_cnt >= BLINK_MID);
    assign blank_p1    = blank_phase && (winner == WIN_P1);
    assign blank_p2    = blank_phase && (winner == WIN_P2);

    assign num1     = (blank_p1 || p1_tens == 4'd0) ? BLANK : p1_tens;
    assign num2     = blank_p1 ? BLANK : p1_ones;
    assign num3     = (blank_p2 || p2_tens == 4'd0) ? BLANK : p2_tens;
    assign num4     = blank_p2 ? BLANK : p2_ones;
    assign flashing = (state == FLASH);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper with FLASH_CYCLES=8, BLINK_HALF=2.
module tb_score_keeper;

    localparam int FC = 8;
    localparam int BH = 2;
    localparam int B  = 11;

    logic       clk = 1'b0;
    logic       rst, p1_win, p2_win, clear_scores;
    logic [3:0] num1, num2, num3, num4;
    logic       flashing;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: integer scores, age since the last accepted win
    int s1 = 0, s2 = 0, age = FC, who = 1;

    score_keeper #(.FLASH_CYCLES(FC), .BLINK_HALF(BH)) dut (
        .clk          (clk),
        .rst          (rst),
        .p1_win       (p1_win),
        .p2_win       (p2_win),
        .clear_scores (clear_scores),
        .num1         (num1),
        .num2         (num2),
        .num3         (num3),
        .num4         (num4),
        .flashing     (flashing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            s1 = 0; s2 = 0; age = FC; who = 1;
        end else if (clear_scores) begin
            s1 = 0; s2 = 0; age = FC;
        end else if (p1_win != p2_win) begin
            if (p1_win) begin
                s1 = (s1 < 99) ? s1 + 1 : 99; who = 1;
            end else begin
                s2 = (s2 < 99) ? s2 + 1 : 99; who = 2;
            end
            age = 0;
        end else if (age < FC) begin
            age = age + 1;
        end
    end

    // Compare every cycle, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            bit fl, bl;
            int e1, e2, e3, e4;
            fl = (age < FC);
            bl = fl && ((age % (2 * BH)) >= BH);
            e1 = ((s1 / 10) == 0 || (bl && who == 1)) ? B : s1 / 10;
            e2 = (bl && who == 1) ? B : s1 % 10;
            e3 = ((s2 / 10) == 0 || (bl && who == 2)) ? B : s2 / 10;
            e4 = (bl && who == 2) ? B : s2 % 10;
            check("num1", int'(num1), e1);
            check("num2", int'(num2), e2);
            check("num3", int'(num3), e3);
            check("num4", int'(num4), e4);
            check("flashing", int'(flashing), int'(fl));
        end
    end

    // Present inputs for one cycle, return at the following falling edge
    task automatic cycle(input logic a, input logic b, input logic c, input logic r);
        p1_win = a; p2_win = b; clear_scores = c; rst = r;
        @(negedge clk);
        p1_win = 1'b0; p2_win = 1'b0; clear_scores = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_digits(input string name, input int a, input int b,
                                 input int c, input int d, input int f);
        check({name, "_n1"}, int'(num1), a);
        check({name, "_n2"}, int'(num2), b);
        check({name, "_n3"}, int'(num3), c);
        check({name, "_n4"}, int'(num4), d);
        check({name, "_fl"}, int'(flashing), f);
    endtask

    initial begin
        int n;
        rst = 1'b1; p1_win = 1'b0; p2_win = 1'b0; clear_scores = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        expect_digits("reset", B, 0, B, 0, 0);

        // Single P1 win: blink pattern and flash length
        cycle(1, 0, 0, 0);
        check("p1_first_ones", int'(num2), 1);
        n = 0;
        while (flashing && n < 50) begin
            check("p1_blink", int'(num2), ((n % 4) < 2) ? 1 : B);
            check("p1_loser", int'(num4), 0);
            n++;
            @(negedge clk);
        end
        check("p1_flash_len", n, 8);

        // Draw is ignored
        cycle(1, 1, 0, 0);
        expect_digits("draw", B, 1, B, 0, 0);

        // Ten P2 wins reach 10
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0);
            idle(9);
        end
        expect_digits("p2_ten", B, 1, 1, 0, 0);

        // P2 win on the 4th cycle of a P1 flash restarts the window
        cycle(1, 0, 0, 0);
        idle(3);
        cycle(0, 1, 0, 0);
        expect_digits("retrig", B, 2, 1, 1, 1);
        n = 0;
        while (flashing && n < 50) begin
            check("retrig_p1_steady", int'(num2), 2);
            n++;
            @(negedge clk);
        end
        check("retrig_flash_len", n, 8);

        // Clear coincident with a win during FLASH
        cycle(0, 1, 0, 0);
        idle(1);
        cycle(1, 0, 1, 0);
        expect_digits("clear_win", B, 0, B, 0, 0);

        // Reset in the middle of FLASH
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle(2);
        cycle(0, 0, 0, 1);
        expect_digits("mid_rst", B, 0, B, 0, 0);

        // Saturation at 99 still (re)starts the flash
        for (int i = 0; i < 99; i++) cycle(1, 0, 0, 0);
        idle(20);
        expect_digits("p1_99", 9, 9, B, 0, 0);
        cycle(1, 0, 0, 0);
        expect_digits("p1_sat", 9, 9, B, 0, 1);
        idle(20);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 150) == 0, $urandom_range(0, 400) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
